noc_mesh_2x2: RTL and testbench

//  2x2 mesh network-on-chip: four routers (node id = {y,x}: 0=(0,0), 1=(1,0), 2=(0,1), 3=(1,1)).

---
 rtl/noc_pkg.sv | 66 ++++++
 rtl/noc_mesh_2x2_if.sv | 41 ++++
 rtl/noc_router.sv | 97 +++++++++
 rtl/noc_mesh_2x2.sv | 90 +++++++++
 tb/tb_noc_mesh_2x2.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared types and constants for the 2x2 mesh: flit layout, node ids, opcodes, XY route helper.
package noc_pkg;

    localparam int unsigned FLIT_W  = 18;
    localparam int unsigned CFG_W   = 11;
    localparam int unsigned RX_W    = 9;
    localparam int unsigned N_NODES = 4;

    typedef logic [1:0] node_t;

    // Node id is {y,x}.
    localparam int unsigned ID_X_BIT = 0;
    localparam int unsigned ID_Y_BIT = 1;

    localparam node_t NODE_00 = 2'd0;
    localparam node_t NODE_10 = 2'd1;
    localparam node_t NODE_01 = 2'd2;
    localparam node_t NODE_11 = 2'd3;

    localparam int unsigned FLIT_VALID_BIT = 17;
    localparam int unsigned FLIT_SRC_LO    = 9;
    localparam int unsigned FLIT_DEST_LO   = 7;

    typedef struct packed {
        logic       valid;
        logic [5:0] rsvd;
        node_t      src;
        node_t      dest;
        logic [6:0] data;
    } flit_t;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_SEND = 2'b01;

    localparam int unsigned CFG_OP_HI   = 10;
    localparam int unsigned CFG_OP_LO   = 9;
    localparam int unsigned CFG_DATA_HI = 8;
    localparam int unsigned CFG_DATA_LO = 2;

    typedef enum logic [1:0] {
        DirX,
        DirY,
        DirEject
    } dir_e;

    function automatic dir_e route(node_t cur, node_t dest);
        if (dest[ID_X_BIT] != cur[ID_X_BIT]) begin
            return DirX;
        end
        if (dest[ID_Y_BIT] != cur[ID_Y_BIT]) begin
            return DirY;
        end
        return DirEject;
    endfunction

    function automatic flit_t make_flit(node_t src, node_t dest, logic [6:0] data);
        flit_t f;
        f       = '0;
        f.valid = 1'b1;
        f.src   = src;
        f.dest  = dest;
        f.data  = data;
        return f;
    endfunction

endpackage

// File: rtl/noc_mesh_2x2_if.sv
// Edge and processor port bundle between the mesh (slave) and the agents attached to it (master).
interface noc_mesh_2x2_if;

    logic [noc_pkg::FLIT_W-1:0] r0_input;
    logic [noc_pkg::FLIT_W-1:0] r1_input;
    logic [noc_pkg::FLIT_W-1:0] r2_input;
    logic [noc_pkg::FLIT_W-1:0] r3_input;
    logic [noc_pkg::CFG_W-1:0]  p0_configure;
    logic [noc_pkg::CFG_W-1:0]  p1_configure;
    logic [noc_pkg::CFG_W-1:0]  p2_configure;
    logic [noc_pkg::CFG_W-1:0]  p3_configure;
    logic                       block_all_paths;
    logic [3:0]                 processor_ready_signals;
    logic [noc_pkg::RX_W-1:0]   p0_recieve_data;
    logic [noc_pkg::RX_W-1:0]   p1_recieve_data;
    logic [noc_pkg::RX_W-1:0]   p2_recieve_data;
    logic [noc_pkg::RX_W-1:0]   p3_recieve_data;
    logic [noc_pkg::FLIT_W-1:0] r0_output;
    logic [noc_pkg::FLIT_W-1:0] r1_output;
    logic [noc_pkg::FLIT_W-1:0] r2_output;
    logic [noc_pkg::FLIT_W-1:0] r3_output;

    modport master (
        output r0_input, r1_input, r2_input, r3_input,
        output p0_configure, p1_configure, p2_configure, p3_configure,
        output block_all_paths,
        input  processor_ready_signals,
        input  p0_recieve_data, p1_recieve_data, p2_recieve_data, p3_recieve_data,
        input  r0_output, r1_output, r2_output, r3_output
    );

    modport slave (
        input  r0_input, r1_input, r2_input, r3_input,
        input  p0_configure, p1_configure, p2_configure, p3_configure,
        input  block_all_paths,
        output processor_ready_signals,
        output p0_recieve_data, p1_recieve_data, p2_recieve_data, p3_recieve_data,
        output r0_output, r1_output, r2_output, r3_output
    );

endinterface

// File: rtl/noc_router.sv
// One mesh router: local/X/Y input registers, XY routing, fixed-priority arbitration and a
// two-stage eject path (eject register, then sticky output register).
module noc_router
    import noc_pkg::*;
#(
    parameter node_t NODE_ID = 2'd0
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  i_block,
    input  logic  i_load,
    input  flit_t i_load_flit,
    output logic  o_local_empty,
    input  flit_t i_x_flit,
    input  logic  i_x_vld,
    input  flit_t i_y_flit,
    input  logic  i_y_vld,
    input  logic  i_x_rdy,
    input  logic  i_y_rdy,
    output flit_t o_x_flit,
    output logic  o_x_vld,
    output flit_t o_y_flit,
    output logic  o_y_vld,
    output logic  o_x_rdy,
    output logic  o_y_rdy,
    output flit_t o_eject
);

    flit_t r_local, r_x, r_y, r_ej, r_out;
    flit_t w_ej_flit;

    // An X-in flit already matches x, and a Y-in flit matches both coordinates.
    wire w_l_req_x  = r_local.valid && (route(NODE_ID, r_local.dest) == DirX);
    wire w_l_req_y  = r_local.valid && (route(NODE_ID, r_local.dest) == DirY);
    wire w_l_req_ej = r_local.valid && (route(NODE_ID, r_local.dest) == DirEject);
    wire w_x_req_y  = r_x.valid && (route(NODE_ID, r_x.dest) == DirY);
    wire w_x_req_ej = r_x.valid && (route(NODE_ID, r_x.dest) == DirEject);
    wire w_y_req_ej = r_y.valid && (route(NODE_ID, r_y.dest) == DirEject);

    // Priority X-in > Y-in > local on each output; the eject stage always accepts.
    wire w_x_mv = !i_block && (w_x_req_ej || (w_x_req_y && i_y_rdy));
    wire w_y_mv = !i_block && w_y_req_ej && !w_x_req_ej;
    wire w_l_mv = !i_block && ((w_l_req_x && i_x_rdy)
                            || (w_l_req_y && !w_x_req_y && i_y_rdy)
                            || (w_l_req_ej && !w_x_req_ej && !w_y_req_ej));

    always_comb begin
        w_ej_flit = '0;
        if (w_x_req_ej) begin
            w_ej_flit = r_x;
        end else if (w_y_req_ej) begin
            w_ej_flit = r_y;
        end else if (w_l_req_ej) begin
            w_ej_flit = r_local;
        end
    end

    assign o_x_flit      = r_local;
    assign o_x_vld       = !i_block && w_l_req_x && i_x_rdy;
    assign o_y_flit      = w_x_req_y ? r_x : r_local;
    assign o_y_vld       = !i_block && i_y_rdy && (w_x_req_y || w_l_req_y);
    assign o_x_rdy       = !r_x.valid || w_x_mv;
    assign o_y_rdy       = !r_y.valid || w_y_mv;
    assign o_local_empty = !r_local.valid;
    assign o_eject       = r_out;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_local <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_ej    <= '0;
            r_out   <= '0;
        end else if (!i_block) begin
            if (i_load) begin
                r_local <= i_load_flit;
            end else if (w_l_mv) begin
                r_local <= '0;
            end
            if (i_x_vld) begin
                r_x <= i_x_flit;
            end else if (w_x_mv) begin
                r_x <= '0;
            end
            if (i_y_vld) begin
                r_y <= i_y_flit;
            end else if (w_y_mv) begin
                r_y <= '0;
            end
            r_ej <= w_ej_flit;
            if (r_ej.valid) begin
                r_out <= r_ej;
            end
        end
    end

endmodule

// File: rtl/noc_mesh_2x2.sv
// 2x2 XY-routed mesh: four routers, X links pair ids differing in bit 0, Y links in bit 1.
// Also owns processor configure edge detection and edge-port admission.
module noc_mesh_2x2
    import noc_pkg::*;
(
    input logic           clock,
    input logic           reset,
    noc_mesh_2x2_if.slave bus
);

    flit_t            w_edge_in   [N_NODES];
    logic [CFG_W-1:0] w_cfg       [N_NODES];
    flit_t            w_eject     [N_NODES];
    flit_t            w_load_flit [N_NODES];
    flit_t            w_x_flit    [N_NODES];
    flit_t            w_y_flit    [N_NODES];

    logic [N_NODES-1:0] r_prev_send;
    logic [N_NODES-1:0] w_local_empty, w_ready, w_inj, w_load;
    logic [N_NODES-1:0] w_x_vld, w_y_vld, w_x_rdy, w_y_rdy;

    assign w_edge_in[0] = bus.r0_input;
    assign w_edge_in[1] = bus.r1_input;
    assign w_edge_in[2] = bus.r2_input;
    assign w_edge_in[3] = bus.r3_input;
    assign w_cfg[0]     = bus.p0_configure;
    assign w_cfg[1]     = bus.p1_configure;
    assign w_cfg[2]     = bus.p2_configure;
    assign w_cfg[3]     = bus.p3_configure;

    // A processor send wins the local slot over an edge flit arriving the same cycle.
    always_comb begin
        for (int i = 0; i < N_NODES; i++) begin
            w_ready[i]     = w_local_empty[i] && !bus.block_all_paths;
            w_inj[i]       = (w_cfg[i][CFG_OP_HI:CFG_OP_LO] == OP_SEND) && !r_prev_send[i]
                             && w_ready[i];
            w_load[i]      = w_inj[i] || (w_edge_in[i].valid && w_ready[i]);
            w_load_flit[i] = w_inj[i]
                ? make_flit(node_t'(i), w_cfg[i][1:0], w_cfg[i][CFG_DATA_HI:CFG_DATA_LO])
                : w_edge_in[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev_send <= '0;
        end else begin
            for (int i = 0; i < N_NODES; i++) begin
                r_prev_send[i] <= (w_cfg[i][CFG_OP_HI:CFG_OP_LO] == OP_SEND);
            end
        end
    end

    for (genvar g = 0; g < N_NODES; g++) begin : g_router
        noc_router #(
            .NODE_ID(node_t'(g))
        ) u_router (
            .clock        (clock),
            .reset        (reset),
            .i_block      (bus.block_all_paths),
            .i_load       (w_load[g]),
            .i_load_flit  (w_load_flit[g]),
            .o_local_empty(w_local_empty[g]),
            .i_x_flit     (w_x_flit[g ^ 1]),
            .i_x_vld      (w_x_vld[g ^ 1]),
            .i_y_flit     (w_y_flit[g ^ 2]),
            .i_y_vld      (w_y_vld[g ^ 2]),
            .i_x_rdy      (w_x_rdy[g ^ 1]),
            .i_y_rdy      (w_y_rdy[g ^ 2]),
            .o_x_flit     (w_x_flit[g]),
            .o_x_vld      (w_x_vld[g]),
            .o_y_flit     (w_y_flit[g]),
            .o_y_vld      (w_y_vld[g]),
            .o_x_rdy      (w_x_rdy[g]),
            .o_y_rdy      (w_y_rdy[g]),
            .o_eject      (w_eject[g])
        );
    end

    assign bus.processor_ready_signals = w_ready;
    assign bus.p0_recieve_data = {w_eject[0].src, w_eject[0].data};
    assign bus.p1_recieve_data = {w_eject[1].src, w_eject[1].data};
    assign bus.p2_recieve_data = {w_eject[2].src, w_eject[2].data};
    assign bus.p3_recieve_data = {w_eject[3].src, w_eject[3].data};
    assign bus.r0_output       = w_eject[0];
    assign bus.r1_output       = w_eject[1];
    assign bus.r2_output       = w_eject[2];
    assign bus.r3_output       = w_eject[3];

endmodule

// File: tb/tb_noc_mesh_2x2.sv
// Bench for noc_mesh_2x2: directed latency/priority/block/reset cases, then random traffic
// scored against a packet-level model (expected set, hop-count latency floor, no loss/dup).
module tb_noc_mesh_2x2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        block = 1'b0;
    logic [10:0] cfg   [4];
    logic [17:0] rin   [4];
    logic [17:0] rout  [4];
    logic [8:0]  prcv  [4];
    logic [3:0]  ready;

    always #5 clock = ~clock;

    noc_mesh_2x2_if bus ();

    assign bus.r0_input        = rin[0];
    assign bus.r1_input        = rin[1];
    assign bus.r2_input        = rin[2];
    assign bus.r3_input        = rin[3];
    assign bus.p0_configure    = cfg[0];
    assign bus.p1_configure    = cfg[1];
    assign bus.p2_configure    = cfg[2];
    assign bus.p3_configure    = cfg[3];
    assign bus.block_all_paths = block;
    assign ready   = bus.processor_ready_signals;
    assign prcv[0] = bus.p0_recieve_data;
    assign prcv[1] = bus.p1_recieve_data;
    assign prcv[2] = bus.p2_recieve_data;
    assign prcv[3] = bus.p3_recieve_data;
    assign rout[0] = bus.r0_output;
    assign rout[1] = bus.r1_output;
    assign rout[2] = bus.r2_output;
    assign rout[3] = bus.r3_output;

    noc_mesh_2x2 dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [17:0] f;
        int          t;
    } pend_t;

    pend_t       pend [$];
    logic [17:0] last [4];
    int          dcnt [4];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;

    function automatic logic [17:0] mk(input int s, input int d, input int data);
        return {1'b1, 6'b0, 2'(s), 2'(d), 7'(data)};
    endfunction

    // Manhattan distance between source and destination coordinates.
    function automatic int hops(input logic [17:0] f);
        return int'(f[9] ^ f[7]) + int'(f[10] ^ f[8]);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        int idx;
        int lat;
        for (int k = 0; k < 4; k++) begin
            if (mon_en && rout[k] !== last[k]) begin
                last[k] = rout[k];
                dcnt[k]++;
                idx = -1;
                foreach (pend[j]) begin
                    if (idx < 0 && pend[j].f == rout[k]) idx = j;
                end
                check("known_packet", 32'(idx >= 0), 1);
                if (idx >= 0) begin
                    lat = cyc - pend[idx].t;
                    check("dest_router", 32'(rout[k][8:7]), 32'(k[1:0]));
                    check("recv_data", 32'(prcv[k]), 32'({rout[k][10:9], rout[k][6:0]}));
                    check("latency_floor", 32'(lat >= 2 + hops(rout[k])), 1);
                    check("latency_bound", 32'(lat <= 60), 1);
                    pend.delete(idx);
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        cyc++;
        @(negedge clock);
        monitor();
    endtask

    task automatic push(input logic [17:0] f);
        pend.push_back('{f: f, t: cyc});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int d0;
    int blk_left;
    int cnt  [4];
    bit busy [4];
    logic [17:0] np [4];
    bit nv [4];
    int r;
    int d;

    initial begin
        for (int i = 0; i < 4; i++) begin
            cfg[i] = '0; rin[i] = '0; last[i] = '0; dcnt[i] = 0; cnt[i] = 0; busy[i] = 0;
        end
        cycle();
        reset  = 1'b0;
        mon_en = 1'b1;
        check("reset_ready", 32'(ready), 32'hF);
        for (int k = 0; k < 4; k++) begin
            check("reset_rout", 32'(rout[k]), 0);
            check("reset_prcv", 32'(prcv[k]), 0);
        end

        // 1 hop, 0 -> 1
        cfg[0] = {2'b01, 7'd1, 2'd1};
        cycle();
        push(mk(0, 1, 1));
        cfg[0] = '0;
        check("t1_ready_busy", 32'(ready), 32'hE);
        cycle();
        check("t1_ready_free", 32'(ready), 32'hF);
        cycle();
        check("t1_early", 32'(prcv[1]), 0);
        cycle();
        check("t1_p1", 32'(prcv[1]), 32'(9'b00_0000001));
        check("t1_r1", 32'(rout[1]), 32'h20081);
        check("t1_r0_quiet", 32'(rout[0]), 0);
        check("t1_r2_quiet", 32'(rout[2]), 0);
        check("t1_r3_quiet", 32'(rout[3]), 0);

        // self-send at 1 collides with 3 -> 1
        d0 = dcnt[1];
        cfg[1] = 11'b01_0000000_01;
        cfg[3] = 11'b01_0000000_01;
        cycle();
        push(mk(1, 1, 0));
        push(mk(3, 1, 0));
        cfg[1] = '0;
        cfg[3] = '0;
        cycle();
        cycle();
        check("t2_first", 32'(prcv[1]), 32'(9'b01_0000000));
        cycle();
        check("t2_second", 32'(prcv[1]), 32'(9'b11_0000000));
        check("t2_count", 32'(dcnt[1] - d0), 2);

        // 2 hops, 0 -> 3
        cfg[0] = {2'b01, 7'h55, 2'd3};
        cycle();
        push(mk(0, 3, 'h55));
        cfg[0] = '0;
        repeat (3) cycle();
        check("t3_early", 32'(rout[3]), 0);
        cycle();
        check("t3_r3", 32'(rout[3]), 32'h20180 | 32'h55);

        // held opcode injects once; re-arm after idle
        d0 = dcnt[1];
        cfg[0] = {2'b01, 7'h11, 2'd1};
        cycle();
        push(mk(0, 1, 'h11));
        check("t4_busy", 32'(ready[0]), 0);
        for (int n = 0; n < 4; n++) begin
            cycle();
            check("t4_no_reinject", 32'(ready[0]), 1);
        end
        cfg[0] = '0;
        cycle();
        cycle();
        check("t4_one_delivery", 32'(dcnt[1] - d0), 1);
        cfg[0] = {2'b01, 7'h12, 2'd1};
        cycle();
        push(mk(0, 1, 'h12));
        cfg[0] = '0;
        check("t4_rearm", 32'(ready[0]), 0);
        repeat (3) cycle();
        check("t4_second_delivery", 32'(dcnt[1] - d0), 2);
        check("t4_second_data", 32'(prcv[1]), 32'h12);

        // global stall with a flit parked in router 1's X-in
        cfg[0] = {2'b01, 7'h22, 2'd3};
        cycle();
        push(mk(0, 3, 'h22));
        cfg[0] = '0;
        cycle();
        d0 = dcnt[3];
        block  = 1'b1;
        rin[2] = mk(2, 0, 'h7f);
        for (int n = 0; n < 10; n++) begin
            cycle();
            rin[2] = '0;
            check("t5_ready_blocked", 32'(ready), 0);
        end
        check("t5_no_delivery", 32'(dcnt[3] - d0), 0);
        block = 1'b0;
        cycle();
        cycle();
        check("t5_resume_early", 32'(dcnt[3] - d0), 0);
        cycle();
        check("t5_resume_r3", 32'(rout[3]), 32'h20180 | 32'h22);

        // reset discards an in-flight flit
        cfg[0] = {2'b01, 7'h33, 2'd3};
        cycle();
        cfg[0] = '0;
        cycle();
        mon_en = 1'b0;
        reset  = 1'b1;
        cycle();
        reset = 1'b0;
        pend.delete();
        for (int k = 0; k < 4; k++) last[k] = '0;
        check("t6_ready", 32'(ready), 32'hF);
        for (int k = 0; k < 4; k++) begin
            check("t6_rout_clear", 32'(rout[k]), 0);
            check("t6_prcv_clear", 32'(prcv[k]), 0);
        end
        mon_en = 1'b1;
        repeat (6) cycle();
        check("t6_no_delivery", 32'(rout[3]), 0);

        // random traffic
        blk_left = 0;
        repeat (300) begin
            for (int i = 0; i < 4; i++) nv[i] = 0;
            if (blk_left > 0) begin
                blk_left--;
                if (blk_left == 0) block = 1'b0;
            end else if ($urandom_range(99) < 3) begin
                block    = 1'b1;
                blk_left = $urandom_range(4, 1);
                for (int i = 0; i < 4; i++) begin
                    cfg[i] = '0; rin[i] = '0; busy[i] = 0;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    rin[i] = '0;
                    cfg[i] = '0;
                    if (busy[i]) begin
                        busy[i] = 0;
                    end else begin
                        r = $urandom_range(99);
                        d = $urandom_range(3);
                        if (r < 25 && ready[i]) begin
                            cfg[i]  = {2'b01, 7'(cnt[i]), 2'(d)};
                            np[i]   = mk(i, d, cnt[i]);
                            nv[i]   = 1;
                            busy[i] = 1;
                            cnt[i]++;
                        end else if (r < 40) begin
                            rin[i] = mk(i, d, cnt[i]);
                            np[i]  = rin[i];
                            nv[i]  = ready[i];
                            cnt[i]++;
                        end else if (r < 44) begin
                            cfg[i] = {1'b1, 1'(r), 7'(cnt[i]), 2'(d)};
                            cnt[i]++;
                        end
                    end
                end
            end
            cycle();
            for (int i = 0; i < 4; i++) begin
                if (nv[i]) push(np[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cfg[i] = '0; rin[i] = '0;
        end
        block = 1'b0;
        repeat (60) cycle();
        check("drain_all_delivered", 32'(pend.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
